// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter for the shared RV32 ALU: grants, drives ALU inputs, registers result, acks winner.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module alu_share_arbiter #(
    parameter int WIDTH = 32,
    parameter int OP_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] b1,
    input  logic [WIDTH-1:0] imm0,
    input  logic [WIDTH-1:0] imm1,
    input  logic             sel0,
    input  logic             sel1,
    input  logic [OP_W-1:0]  op0,
    input  logic [OP_W-1:0]  op1,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OP_W-1:0]  alu_op,
    input  logic [WIDTH-1:0] alu_result,
    output logic [1:0]       ack,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_grant;
    logic             w_grant_nxt;
    logic             w_pick;
    logic [WIDTH-1:0] r_result;

`ifdef ALU_ARB_FIXED_PRIO_EN
    // Requester 0 wins whenever it is asking.
    always_comb begin
        w_pick = ~req[0];
    end
`else
    logic r_last;

    // On a tie the requester that did not win last time gets the ALU.
    always_comb begin
        w_pick = (req == 2'b11) ? ~r_last : req[1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (r_state == ST_RESP) begin
            r_last <= r_grant;
        end
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        case (r_state)
            ST_IDLE: begin
                if (|req) begin
                    w_grant_nxt = w_pick;
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: w_state_nxt = ST_RESP;
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_grant  <= 1'b0;
            r_result <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            if (r_state == ST_EXEC) begin
                r_result <= alu_result;
            end
        end
    end

    // ALU inputs are live only while executing so the ALU sees zeros otherwise.
    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = '0;
        if (r_state == ST_EXEC) begin
            if (r_grant) begin
                alu_a  = a1;
                alu_b  = sel1 ? imm1 : b1;
                alu_op = op1;
            end else begin
                alu_a  = a0;
                alu_b  = sel0 ? imm0 : b0;
                alu_op = op0;
            end
        end
    end

    always_comb begin
        ack = 2'b00;
        if (r_state == ST_RESP) begin
            ack[r_grant] = 1'b1;
        end
    end

    assign result = r_result;
    assign busy   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: vector table, corner sequences, randomized model check.
module tb_alu_share_arbiter;

    localparam int WIDTH = 32;
    localparam int OP_W  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req;
    logic [WIDTH-1:0] a0, a1, b0, b1, imm0, imm1;
    logic             sel0, sel1;
    logic [OP_W-1:0]  op0, op1;
    logic [WIDTH-1:0] alu_a, alu_b;
    logic [OP_W-1:0]  alu_op;
    logic [WIDTH-1:0] alu_result;
    logic [1:0]       ack;
    logic [WIDTH-1:0] result;
    logic             busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.WIDTH(WIDTH), .OP_W(OP_W)) dut (
        .clk(clk), .rst(rst), .req(req),
        .a0(a0), .a1(a1), .b0(b0), .b1(b1), .imm0(imm0), .imm1(imm1),
        .sel0(sel0), .sel1(sel1), .op0(op0), .op1(op1),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .ack(ack), .result(result), .busy(busy)
    );

    // External ALU model: op 0 adds; a few other codes give distinct functions.
    function automatic logic [WIDTH-1:0] alu_fn(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                                input logic [OP_W-1:0] op);
        case (op)
            4'd0:    alu_fn = x + y;
            4'd1:    alu_fn = x - y;
            4'd2:    alu_fn = x ^ y;
            default: alu_fn = x & y;
        endcase
    endfunction

    always_comb alu_result = alu_fn(alu_a, alu_b, alu_op);

    typedef struct {
        logic [1:0]       req;
        logic [WIDTH-1:0] a0, b0, imm0;
        logic             sel0;
        logic [OP_W-1:0]  op0;
        logic [WIDTH-1:0] a1, b1, imm1;
        logic             sel1;
        logic [OP_W-1:0]  op1;
        logic [1:0]       e_ack;
        logic [WIDTH-1:0] e_a, e_b;
        logic [OP_W-1:0]  e_op;
        logic [WIDTH-1:0] e_res;
    } vec_t;

    vec_t vt[7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic set_ops(input vec_t v);
        a0 = v.a0; b0 = v.b0; imm0 = v.imm0; sel0 = v.sel0; op0 = v.op0;
        a1 = v.a1; b1 = v.b1; imm1 = v.imm1; sel1 = v.sel1; op1 = v.op1;
    endtask

    // One full transaction, entered and left on a falling edge with the DUT idle.
    task automatic do_txn(input string nm, input vec_t v, input bit drop_early);
        set_ops(v);
        req = v.req;
        @(negedge clk);
        chk({nm, ".exec_busy"}, 64'(busy), 64'd1);
        chk({nm, ".exec_ack"}, 64'(ack), 64'd0);
        chk({nm, ".alu_a"}, 64'(alu_a), 64'(v.e_a));
        chk({nm, ".alu_b"}, 64'(alu_b), 64'(v.e_b));
        chk({nm, ".alu_op"}, 64'(alu_op), 64'(v.e_op));
        if (drop_early) req = 2'b00;
        @(negedge clk);
        chk({nm, ".ack"}, 64'(ack), 64'(v.e_ack));
        chk({nm, ".result"}, 64'(result), 64'(v.e_res));
        chk({nm, ".resp_alu_a"}, 64'(alu_a), 64'd0);
        req = 2'b00;
        @(negedge clk);
        chk({nm, ".idle_ack"}, 64'(ack), 64'd0);
        chk({nm, ".idle_busy"}, 64'(busy), 64'd0);
        chk({nm, ".held_result"}, 64'(result), 64'(v.e_res));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 2'b00;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] acks[$];
        logic [1:0] exp_seq[4];
        int         n_ack;
        int         last_w;
        vec_t       v;

        vt[0] = '{2'b01, 32'hF, 32'h0, 32'hA, 1'b1, 4'd0, 32'h0, 32'h0, 32'h0, 1'b0, 4'd0,
                  2'b01, 32'hF, 32'hA, 4'd0, 32'h19};
        vt[1] = '{2'b10, 32'h0, 32'h0, 32'h0, 1'b0, 4'd0, 32'hF, 32'h3, 32'hA, 1'b0, 4'd0,
                  2'b10, 32'hF, 32'h3, 4'd0, 32'h12};
        vt[2] = '{2'b10, 32'h0, 32'h0, 32'h0, 1'b0, 4'd0, 32'hF, 32'h3, 32'hA, 1'b1, 4'd0,
                  2'b10, 32'hF, 32'hA, 4'd0, 32'h19};
        vt[3] = '{2'b01, 32'hFFFFFFFF, 32'h1, 32'h5, 1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 1'b0, 4'd0,
                  2'b01, 32'hFFFFFFFF, 32'h1, 4'd0, 32'h0};
        vt[4] = '{2'b10, 32'h0, 32'h0, 32'h0, 1'b0, 4'd0, 32'h7FFFFFFF, 32'h12345678, 32'h9, 1'b0, 4'd2,
                  2'b10, 32'h7FFFFFFF, 32'h12345678, 4'd2, 32'h6DCBA987};
        vt[5] = '{2'b11, 32'h11, 32'h22, 32'h33, 1'b1, 4'd0, 32'h1000, 32'h2000, 32'h3000, 1'b0, 4'd1,
                  2'b01, 32'h11, 32'h33, 4'd0, 32'h44};
`ifdef ALU_ARB_FIXED_PRIO_EN
        vt[6] = '{2'b11, 32'h11, 32'h22, 32'h33, 1'b1, 4'd0, 32'h1000, 32'h2000, 32'h3000, 1'b0, 4'd1,
                  2'b01, 32'h11, 32'h33, 4'd0, 32'h44};
        exp_seq = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
        vt[6] = '{2'b11, 32'h11, 32'h22, 32'h33, 1'b1, 4'd0, 32'h1000, 32'h2000, 32'h3000, 1'b0, 4'd1,
                  2'b10, 32'h1000, 32'h2000, 4'd1, 32'hFFFFF000};
        exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif

        req = 2'b00;
        set_ops(vt[5]);
        do_reset();
        chk("rst.ack", 64'(ack), 64'd0);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.result", 64'(result), 64'd0);
        chk("rst.alu_a", 64'(alu_a), 64'd0);
        chk("rst.alu_b", 64'(alu_b), 64'd0);
        chk("rst.alu_op", 64'(alu_op), 64'd0);

        for (int i = 0; i < 7; i++) begin
            do_txn($sformatf("vec%0d", i), vt[i], 1'b0);
        end

        // Both requesters held continuously across several operations.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req = 2'b11;
        n_ack = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (ack != 2'b00) acks.push_back(ack);
        end
        req = 2'b00;
        @(negedge clk);
        chk("rr.count", 64'(acks.size()), 64'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < acks.size()) chk($sformatf("rr.ack%0d", k), 64'(acks[k]), 64'(exp_seq[k]));
        end

        // Operand changed in the response cycle; ALU inputs zero outside execute.
        v = vt[0];
        v.a0 = 32'h100; v.b0 = 32'h23; v.sel0 = 1'b0; v.op0 = 4'd4;
        set_ops(v);
        @(negedge clk);
        chk("t5.idle_alu_a", 64'(alu_a), 64'd0);
        chk("t5.idle_alu_b", 64'(alu_b), 64'd0);
        chk("t5.idle_alu_op", 64'(alu_op), 64'd0);
        op0 = 4'd0;
        req = 2'b01;
        @(negedge clk);
        chk("t5.exec_alu_a", 64'(alu_a), 64'h100);
        @(negedge clk);
        a0 = 32'hDEAD;
        #1;
        chk("t5.result", 64'(result), 64'h123);
        chk("t5.resp_alu_a", 64'(alu_a), 64'd0);
        chk("t5.resp_alu_b", 64'(alu_b), 64'd0);
        chk("t5.resp_alu_op", 64'(alu_op), 64'd0);
        req = 2'b00;
        @(negedge clk);
        chk("t5.after_result", 64'(result), 64'h123);
        chk("t5.after_alu_a", 64'(alu_a), 64'd0);

        // Request withdrawn during execute still completes exactly once.
        a0 = 32'h7; b0 = 32'h8; sel0 = 1'b0; op0 = 4'd0;
        req = 2'b01;
        @(negedge clk);
        req = 2'b00;
        n_ack = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (ack != 2'b00) begin
                n_ack++;
                chk("t6.ack", 64'(ack), 64'd1);
            end
        end
        chk("t6.ack_count", 64'(n_ack), 64'd1);
        chk("t6.result", 64'(result), 64'hF);

        // Reset in the execute cycle aborts the operation.
        a0 = 32'h40; b0 = 32'h2; sel0 = 1'b0; op0 = 4'd0;
        req = 2'b01;
        @(negedge clk);
        chk("t4.busy", 64'(busy), 64'd1);
        rst = 1'b1;
        req = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        chk("t4.ack", 64'(ack), 64'd0);
        chk("t4.result", 64'(result), 64'd0);
        chk("t4.busy_cleared", 64'(busy), 64'd0);
        @(negedge clk);
        chk("t4.no_late_ack", 64'(ack), 64'd0);
        chk("t4.idle", 64'(busy), 64'd0);
        do_txn("t4.tie_after_rst", vt[5], 1'b0);

        // Randomized transactions against an arbitration/result model.
        do_reset();
        last_w = 1;
        for (int t = 0; t < 200; t++) begin
            int w;
            int gap;
            logic [WIDTH-1:0] bsrc;
            v.req  = 2'($urandom_range(1, 3));
            v.a0   = $urandom; v.b0 = $urandom; v.imm0 = $urandom;
            v.a1   = $urandom; v.b1 = $urandom; v.imm1 = $urandom;
            v.sel0 = 1'($urandom); v.sel1 = 1'($urandom);
            v.op0  = 4'($urandom_range(0, 3)); v.op1 = 4'($urandom_range(0, 3));
            if (v.req == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
                w = 0;
`else
                w = 1 - last_w;
`endif
            end else begin
                w = (v.req == 2'b10) ? 1 : 0;
            end
            last_w  = w;
            v.e_ack = (w == 1) ? 2'b10 : 2'b01;
            v.e_a   = (w == 1) ? v.a1 : v.a0;
            bsrc    = (w == 1) ? (v.sel1 ? v.imm1 : v.b1) : (v.sel0 ? v.imm0 : v.b0);
            v.e_b   = bsrc;
            v.e_op  = (w == 1) ? v.op1 : v.op0;
            v.e_res = alu_fn(v.e_a, v.e_b, v.e_op);
            do_txn($sformatf("rnd%0d", t), v, ($urandom_range(0, 3) == 0));
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                chk($sformatf("rnd%0d.gap_ack", t), 64'(ack), 64'd0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
